// File: rtl/pll_retune_pkg.sv
// pll_retune_pkg: reconfig register map, preset entry layout and controller states
package pll_retune_pkg;
  localparam logic [5:0] A_MODE = 6'h00, A_START = 6'h02, A_N = 6'h03, A_M = 6'h04, A_C = 6'h05, A_K = 6'h07;
  localparam int FW = 18, KW = 32, M_LSB = 0, N_LSB = 18, C_LSB = 36;
  typedef enum logic [3:0] {IDLE, MODE, WR_M, WR_N, WR_C, WR_K, START, GUARD, WAIT_LOCK} state_t;
  function automatic int ew(input int nc);
    return C_LSB + KW + FW * nc;
  endfunction
endpackage

// File: rtl/pll_mgmt_writer.sv
// pll_mgmt_writer: registered Avalon-MM write channel holding each write until waitrequest drops
module pll_mgmt_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  addr,
  input  logic [31:0] data,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        wr_done
);
  assign wr_done = mgmt_write && !mgmt_waitrequest;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else if (!mgmt_write || !mgmt_waitrequest) begin
      mgmt_write     <= start;
      mgmt_address   <= addr;
      mgmt_writedata <= data;
    end
endmodule

// File: rtl/pll_retune_ctrl.sv
// pll_retune_ctrl: programs a selected preset into the PLL reconfig IP and supervises re-lock with retries
module pll_retune_ctrl import pll_retune_pkg::*; #(
  parameter int NUM_PRESETS = 4,
  parameter int NUM_C = 1,
  parameter logic [NUM_PRESETS*ew(NUM_C)-1:0] PRESETS = '0,
  parameter int INIT_SEL = 0,
  parameter int LOCK_GUARD = 8,
  parameter int LOCK_STABLE = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY = 2,
  localparam int SW = $clog2(NUM_PRESETS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [SW-1:0] req_sel,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] cur_sel,
  input  logic          pll_locked,
  output logic [5:0]    mgmt_address,
  output logic          mgmt_write,
  output logic [31:0]   mgmt_writedata,
  input  logic          mgmt_waitrequest
);
  localparam int EW = ew(NUM_C);
  localparam int CW = $clog2((LOCK_TIMEOUT > LOCK_GUARD ? LOCK_TIMEOUT : LOCK_GUARD) + 1);
  localparam int TW = $clog2(LOCK_STABLE + 1);
  localparam int AW = $clog2(MAX_RETRY + 2);
  localparam int SN = 1 << SW;
  localparam logic [SN-1:0] VALID = SN'((64'd1 << NUM_PRESETS) - 64'd1);
  state_t state, nxt;
  logic [CW-1:0] cnt, ncnt;
  logic [TW-1:0] stab, nstab;
  logic [AW-1:0] att, natt;
  logic [1:0] ci, nci;
  logic [SW-1:0] sel_q;
  logic s1, s2, err_inv, fail, issue, wr_done;
  logic [5:0] wa;
  logic [31:0] wd;
  logic [EW-1:0] tab [NUM_PRESETS];
  logic [EW-1:0] e;
  for (genvar p = 0; p < NUM_PRESETS; p++) begin : g_tab
    assign tab[p] = PRESETS[p*EW +: EW];
  end
  // data for the write launched at this edge comes from the request itself when leaving IDLE
  assign e = tab[state == IDLE ? req_sel : sel_q];
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign err = err_inv || fail;
  always_comb begin
    nxt = state;
    ncnt = cnt;
    nstab = stab;
    natt = att;
    nci = ci;
    issue = 1'b0;
    done = 1'b0;
    fail = 1'b0;
    case (state)
      IDLE: if (req_valid && VALID[req_sel]) begin
        nxt = MODE;
        natt = '0;
        issue = 1'b1;
      end
      MODE, WR_M, WR_N, WR_K, START: if (wr_done) begin
        nxt = state_t'(state + 4'd1);
        issue = state != START;
        nci = '0;
        ncnt = '0;
      end
      WR_C: if (wr_done) begin
        nxt = ci == 2'(NUM_C - 1) ? WR_K : WR_C;
        nci = ci + 2'd1;
        issue = 1'b1;
      end
      GUARD: begin
        ncnt = cnt + 1'b1;
        if (cnt == CW'(LOCK_GUARD - 1)) begin
          nxt = WAIT_LOCK;
          ncnt = '0;
          nstab = '0;
        end
      end
      WAIT_LOCK: begin
        ncnt = cnt + 1'b1;
        nstab = s2 ? stab + 1'b1 : '0;
        if (s2 && stab == TW'(LOCK_STABLE - 1)) begin
          done = 1'b1;
          nxt = IDLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          if (att == AW'(MAX_RETRY)) begin
            fail = 1'b1;
            nxt = IDLE;
          end else begin
            natt = att + 1'b1;
            nxt = MODE;
            issue = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    wa = '0;
    wd = '0;
    case (nxt)
      MODE: wa = A_MODE;
      WR_M: begin
        wa = A_M;
        wd = {14'b0, e[M_LSB +: FW]};
      end
      WR_N: begin
        wa = A_N;
        wd = {14'b0, e[N_LSB +: FW]};
      end
      WR_C: begin
        wa = A_C;
        wd = {12'b0, nci, e[C_LSB + FW*nci +: FW]};
      end
      WR_K: begin
        wa = A_K;
        wd = e[EW-1 -: KW];
      end
      START: wa = A_START;
      default: wa = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      stab <= '0;
      att <= '0;
      ci <= '0;
      sel_q <= '0;
      cur_sel <= SW'(INIT_SEL);
      err_inv <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= ncnt;
      stab <= nstab;
      att <= natt;
      ci <= nci;
      sel_q <= state == IDLE && req_valid ? req_sel : sel_q;
      cur_sel <= done ? sel_q : cur_sel;
      err_inv <= state == IDLE && req_valid && !VALID[req_sel];
      s1 <= pll_locked;
      s2 <= s1;
    end
  pll_mgmt_writer u_wr (
    .clk(clk),
    .rst_n(rst_n),
    .start(issue),
    .addr(wa),
    .data(wd),
    .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_write(mgmt_write),
    .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata),
    .wr_done(wr_done)
  );
endmodule
